// File: rtl/pj_pkg.sv
// Purpose: shared types and constants for the MindFocus stimulus display block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pj_pkg;

    localparam int PJ_N_LEDS  = 4;
    localparam int PJ_N_ITENS = 2;
    localparam int PJ_IDX_W   = PJ_N_LEDS * PJ_N_ITENS;

    // Debug-visible state encoding; codes 6 and 7 are unused and recover to OCIOSO.
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        MOSTRA0 = 3'd2,
        PAUSA   = 3'd3,
        MOSTRA1 = 3'd4,
        FIM     = 3'd5
    } pj_estado_t;

    // Larger of two timing parameters, used to size the shared timer.
    function automatic int pj_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pj_temporizador.sv
// Purpose: loadable down-counter shared by all timed display states.
// Latency: fim is high in the cycle the registered count equals 1 (valor cycles after load).
// Backpressure: none; counts every cycle and parks at zero.
module pj_temporizador
    import pj_pkg::*;
#(
    parameter int W = 13
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic [W-1:0] valor,
    output logic         fim
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; a zero count stays at zero so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (carrega) begin
            cnt_d = valor;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (cnt_q == W'(1));

endmodule

// File: rtl/pj_exibidor_estimulos.sv
// Purpose: latches an 8-bit index word and shows its two LED patterns in sequence (macro PJ_EXIBIDOR_CANCELA_EN adds abort input cancela).
// Latency: pronto pulses in the cycle after edge k+2+2*T_ON+T_OFF when iniciar is sampled at edge k.
// Backpressure: none; iniciar outside OCIOSO is dropped, not queued.
module pj_exibidor_estimulos
    import pj_pkg::*;
#(
    parameter int T_ON  = 5000,
    parameter int T_OFF = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef PJ_EXIBIDOR_CANCELA_EN
    input  logic                 cancela,
`endif
    input  logic                 iniciar,
    input  logic [PJ_IDX_W-1:0]  indices,
    output logic [PJ_N_LEDS-1:0] leds,
    output logic                 exibindo,
    output logic                 pronto,
    output logic [2:0]           db_estado
);

    localparam int            TW      = $clog2(pj_max(T_ON, T_OFF) + 1);
    localparam logic [TW-1:0] T_ON_V  = TW'(T_ON);
    localparam logic [TW-1:0] T_OFF_V = TW'(T_OFF);

    pj_estado_t           state_q, state_d;
    logic [PJ_IDX_W-1:0]  latched_q, latched_d;
    logic [PJ_N_LEDS-1:0] leds_q, leds_d;
    logic                 exibindo_q, exibindo_d;
    logic                 pronto_q, pronto_d;

    logic                 tmr_carrega;
    logic [TW-1:0]        tmr_valor;
    logic                 tmr_fim;

    // Next-state logic; an abort request overrides both start and timer expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCIOSO:  if (iniciar) state_d = CARREGA;
            CARREGA: state_d = MOSTRA0;
            MOSTRA0: begin
                if (tmr_fim) begin
                    if (T_OFF == 0) state_d = MOSTRA1;
                    else            state_d = PAUSA;
                end
            end
            PAUSA:   if (tmr_fim) state_d = MOSTRA1;
            MOSTRA1: if (tmr_fim) state_d = FIM;
            FIM:     state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
`ifdef PJ_EXIBIDOR_CANCELA_EN
        if (cancela && (state_q != OCIOSO)) begin
            state_d = FIM;
        end
`endif
    end

    // Timer is reloaded on every entry into a timed state with that state's duration.
    always_comb begin
        tmr_carrega = 1'b0;
        tmr_valor   = T_ON_V;
        if (state_d != state_q) begin
            case (state_d)
                MOSTRA0, MOSTRA1: tmr_carrega = 1'b1;
                PAUSA: begin
                    tmr_carrega = 1'b1;
                    tmr_valor   = T_OFF_V;
                end
                default: tmr_carrega = 1'b0;
            endcase
        end
    end

    // Output and latch next values, computed from the upcoming state so the flops line up with it.
    always_comb begin
        latched_d = latched_q;
        if (state_q == CARREGA) begin
            latched_d = indices;
        end
        case (state_d)
            MOSTRA0: leds_d = latched_d[PJ_N_LEDS-1:0];
            MOSTRA1: leds_d = latched_d[2*PJ_N_LEDS-1:PJ_N_LEDS];
            default: leds_d = '0;
        endcase
        exibindo_d = (state_d != OCIOSO) && (state_d != FIM);
        pronto_d   = (state_q == FIM) && (state_d == OCIOSO);
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OCIOSO;
            latched_q  <= '0;
            leds_q     <= '0;
            exibindo_q <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            latched_q  <= latched_d;
            leds_q     <= leds_d;
            exibindo_q <= exibindo_d;
            pronto_q   <= pronto_d;
        end
    end

    pj_temporizador #(
        .W (TW)
    ) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .carrega (tmr_carrega),
        .valor   (tmr_valor),
        .fim     (tmr_fim)
    );

    assign leds      = leds_q;
    assign exibindo  = exibindo_q;
    assign pronto    = pronto_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_pj_exibidor_estimulos.sv
// Purpose: self-checking bench for pj_exibidor_estimulos with a gapped (T_OFF=2) and a gapless (T_OFF=0) instance.
// Latency: expected outputs come from a per-cycle timeline model keyed on cycles since the start edge.
// Backpressure: not applicable.
module tb_pj_exibidor_estimulos;

    logic       clock = 1'b0;
    logic       reset_a, reset_b;
    logic       iniciar_a, iniciar_b;
    logic [7:0] indices_a, indices_b;
    logic [3:0] leds_a, leds_b;
    logic       exibindo_a, exibindo_b;
    logic       pronto_a, pronto_b;
    logic [2:0] db_estado_a, db_estado_b;
`ifdef PJ_EXIBIDOR_CANCELA_EN
    logic       cancela_a = 1'b0;
    logic       cancela_b = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pj_exibidor_estimulos #(.T_ON(4), .T_OFF(2)) dut_a (
        .clock     (clock),
        .reset     (reset_a),
`ifdef PJ_EXIBIDOR_CANCELA_EN
        .cancela   (cancela_a),
`endif
        .iniciar   (iniciar_a),
        .indices   (indices_a),
        .leds      (leds_a),
        .exibindo  (exibindo_a),
        .pronto    (pronto_a),
        .db_estado (db_estado_a)
    );

    pj_exibidor_estimulos #(.T_ON(4), .T_OFF(0)) dut_b (
        .clock     (clock),
        .reset     (reset_b),
`ifdef PJ_EXIBIDOR_CANCELA_EN
        .cancela   (cancela_b),
`endif
        .iniciar   (iniciar_b),
        .indices   (indices_b),
        .leds      (leds_b),
        .exibindo  (exibindo_b),
        .pronto    (pronto_b),
        .db_estado (db_estado_b)
    );

    // Expected {state, leds, exibindo, pronto} j cycles after the edge that sampled iniciar.
    function automatic logic [8:0] model(input int j, input logic [7:0] idx,
                                         input int ton, input int toff);
        logic [2:0] st;
        logic [3:0] l;
        logic       ex;
        logic       pr;
        l  = 4'h0;
        ex = 1'b1;
        pr = 1'b0;
        if (j == 0) begin
            st = 3'd1;
        end else if (j <= ton) begin
            st = 3'd2;
            l  = idx[3:0];
        end else if (j <= ton + toff) begin
            st = 3'd3;
        end else if (j <= 2 * ton + toff) begin
            st = 3'd4;
            l  = idx[7:4];
        end else if (j == 2 * ton + toff + 1) begin
            st = 3'd5;
            ex = 1'b0;
        end else begin
            st = 3'd0;
            ex = 1'b0;
            pr = 1'b1;
        end
        return {st, l, ex, pr};
    endfunction

    function automatic logic [8:0] obs(input int d);
        if (d == 0) return {db_estado_a, leds_a, exibindo_a, pronto_a};
        return {db_estado_b, leds_b, exibindo_b, pronto_b};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ini(input int d, input logic v);
        if (d == 0) iniciar_a = v; else iniciar_b = v;
    endtask

    task automatic set_idx(input int d, input logic [7:0] v);
        if (d == 0) indices_a = v; else indices_b = v;
    endtask

    task automatic set_rst(input int d, input logic v);
        if (d == 0) reset_a = v; else reset_b = v;
    endtask

    task automatic check(input string tag, input int j, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s j=%0d observed{st,leds,exib,pronto}=%h expected=%h", tag, j, o, e);
        end
    endtask

    task automatic check_excl(input string tag, input int j, input logic [8:0] o);
        checks++;
        assert (!(o[1] && o[0])) else begin
            errors++;
            $error("FAIL %s_excl j=%0d observed exibindo=%b pronto=%b required not both high", tag, j, o[1], o[0]);
        end
    endtask

    // mode 0: plain run; 1: indices disturbed in MOSTRA0 and iniciar pulsed in MOSTRA1;
    // 2: reset in first PAUSA cycle; 3: iniciar held high throughout (back-to-back restart).
    task automatic run_seq(input string tag, input int d, input logic [7:0] idx, input int mode);
        int ton, toff, last;
        logic [8:0] o;
        ton  = 4;
        toff = (d == 0) ? 2 : 0;
        last = 2 * ton + toff + 2;
        set_idx(d, idx);
        set_ini(d, 1'b1);
        step();
        if (mode != 3) set_ini(d, 1'b0);
        for (int j = 0; j <= last; j++) begin
            o = obs(d);
            check(tag, j, o, model(j, idx, ton, toff));
            check_excl(tag, j, o);
            if (mode == 2 && j == ton + 1) begin
                set_rst(d, 1'b1);
                step();
                check({tag, "_rst"}, j + 1, obs(d), 9'h000);
                set_rst(d, 1'b0);
                for (int k = 0; k < 3; k++) begin
                    step();
                    check({tag, "_idle"}, k, obs(d), 9'h000);
                end
                return;
            end
            if (mode == 1 && j == 1)               set_idx(d, 8'hFF);
            if (mode == 1 && j == ton + toff + 1)  set_ini(d, 1'b1);
            if (mode == 1 && j == ton + toff + 2)  set_ini(d, 1'b0);
            if (j < last) step();
        end
        step();
        if (mode == 3) begin
            check({tag, "_restart"}, last + 1, obs(d), {3'd1, 4'h0, 1'b1, 1'b0});
            set_ini(d, 1'b0);
            set_rst(d, 1'b1);
            step();
            set_rst(d, 1'b0);
            check({tag, "_rst"}, last + 2, obs(d), 9'h000);
        end else begin
            check({tag, "_after"}, last + 1, obs(d), 9'h000);
        end
    endtask

    initial begin
        reset_a   = 1'b1;
        reset_b   = 1'b1;
        iniciar_a = 1'b0;
        iniciar_b = 1'b0;
        indices_a = 8'h00;
        indices_b = 8'h00;
        step();
        step();
        check("reset_a", 0, obs(0), 9'h000);
        check("reset_b", 0, obs(1), 9'h000);
        reset_a = 1'b0;
        reset_b = 1'b0;
        step();
        check("idle_a", 0, obs(0), 9'h000);
        check("idle_b", 0, obs(1), 9'h000);

        run_seq("basic_21", 0, 8'h21, 0);
        run_seq("nogap_84", 1, 8'h84, 0);
        run_seq("disturb_a", 0, 8'h3C, 1);
        run_seq("disturb_b", 1, 8'hC3, 1);
        run_seq("rst_pausa", 0, 8'h5A, 2);
        run_seq("fresh_a", 0, 8'h96, 0);
        run_seq("zero_a", 0, 8'h00, 0);
        run_seq("zero_b", 1, 8'h00, 0);
        run_seq("b2b_a", 0, 8'h71, 3);
        run_seq("b2b_b", 1, 8'h1E, 3);

        for (int r = 0; r < 8; r++) begin
            int         d;
            int         gap;
            logic [7:0] idx;
            d   = int'($urandom_range(1, 0));
            idx = 8'($urandom);
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) begin
                step();
                check("rand_gap", g, obs(d), 9'h000);
            end
            run_seq("rand", d, idx, 0);
        end

`ifdef PJ_EXIBIDOR_CANCELA_EN
        set_idx(0, 8'hA5);
        set_ini(0, 1'b1);
        step();
        set_ini(0, 1'b0);
        for (int j = 0; j <= 2; j++) begin
            check("cancel_pre", j, obs(0), model(j, 8'hA5, 4, 2));
            if (j < 2) step();
        end
        cancela_a = 1'b1;
        step();
        cancela_a = 1'b0;
        check("cancel_fim", 3, obs(0), {3'd5, 4'h0, 1'b0, 1'b0});
        step();
        check("cancel_pronto", 4, obs(0), {3'd0, 4'h0, 1'b0, 1'b1});
        step();
        check("cancel_idle", 5, obs(0), 9'h000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
